// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg
// Shared definitions for the scoreboarded register file: the soft-clear FSM
// state encoding, default geometry and the number of read ports.
// Optional feature macro used by regfile_sb: REGFILE_SB_BYPASS_EN.
package regfile_sb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 3;
    localparam int NUM_RD_PORTS   = 3;

endpackage

// File: rtl/regfile_sb_clr_fsm.sv
// regfile_sb_clr_fsm
// Sequences the soft clear of the register file. While idle it accepts a
// clear request; it then walks a counter over every entry, one per cycle,
// and returns to idle after the last entry has been cleared.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clr_req_i         request a soft clear (honoured only while idle)
//   ready_o           1 = idle, register file accepts writes/busy-sets
//   clr_active_o      1 = an entry is being cleared this cycle
//   clr_addr_o        entry being cleared this cycle
import regfile_sb_pkg::*;

module regfile_sb_clr_fsm #(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req_i,
    output logic              ready_o,
    output logic              clr_active_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q;

    // The counter wraps to zero by itself after the last entry, so it is
    // already primed for the next sweep when the FSM drops back to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_req_i) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o      = ready_q;
    assign clr_active_o = (state_q == ST_CLEAR);
    assign clr_addr_o   = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// Parametrised register file with three combinational read ports, one
// synchronous write port, a per-register pending-write scoreboard, an
// optional hard-wired zero register and a sequenced soft clear.
// Optional feature: define REGFILE_SB_BYPASS_EN to forward an accepted
// write straight to any read port addressing the same entry.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   we, waddr, wdata      writeback port (clears the entry's busy bit)
//   ra1..ra3 / rd1..rd3   read addresses / data (src1, src2, dst)
//   bs_set, bs_addr       mark an entry busy at issue
//   busy1..busy3          scoreboard bit of each read address
//   clr_req               request a soft clear of all entries and busy bits
//   ready                 1 = idle, writes / bs_set / clr_req accepted
import regfile_sb_pkg::*;

module regfile_sb #(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    input  logic              bs_set,
    input  logic [ADDR_W-1:0] bs_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              busy3,
    input  logic              clr_req,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;

    logic              clrActive;
    logic [ADDR_W-1:0] clrAddr;
    logic              writeHit;
    logic              setHit;

    logic [ADDR_W-1:0] raddr [NUM_RD_PORTS];
    logic [DATA_W-1:0] rdata [NUM_RD_PORTS];
    logic [NUM_RD_PORTS-1:0] rbusy;

    function automatic logic isZeroReg(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    regfile_sb_clr_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clr_fsm (
        .clk         (clk),
        .rst         (rst),
        .clr_req_i   (clr_req),
        .ready_o     (ready),
        .clr_active_o(clrActive),
        .clr_addr_o  (clrAddr)
    );

    // Writes and busy-sets to the hard-wired zero entry are dropped here so
    // that entry 0 never holds anything but its reset value.
    assign writeHit = we && ready && !isZeroReg(waddr);
    assign setHit   = bs_set && ready && !isZeroReg(bs_addr);

    // Busy-set is applied after the write so that a same-address collision
    // leaves the entry busy: a newer producer has been issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (clrActive) begin
            mem_q[clrAddr]  <= '0;
            busy_q[clrAddr] <= 1'b0;
        end else begin
            if (writeHit) begin
                mem_q[waddr]  <= wdata;
                busy_q[waddr] <= 1'b0;
            end
            if (setHit) begin
                busy_q[bs_addr] <= 1'b1;
            end
        end
    end

    assign raddr[0] = ra1;
    assign raddr[1] = ra2;
    assign raddr[2] = ra3;

    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rdata[p] = mem_q[raddr[p]];
            rbusy[p] = busy_q[raddr[p]];
`ifdef REGFILE_SB_BYPASS_EN
            if (writeHit && (waddr == raddr[p])) begin
                rdata[p] = wdata;
                rbusy[p] = setHit && (bs_addr == waddr);
            end
`endif
            if (isZeroReg(raddr[p])) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign rd1   = rdata[0];
    assign rd2   = rdata[1];
    assign rd3   = rdata[2];
    assign busy1 = rbusy[0];
    assign busy2 = rbusy[1];
    assign busy3 = rbusy[2];

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 8x16 processor register file.
- Generic width and depth, three combinational read ports (src1, src2, dst-for-store), one synchronous write port.
- Adds a per-register scoreboard (pending-write busy bits) for hazard detection, an optional hard-wired zero register, and a sequenced soft-clear engine.
- Sits between decode (read and busy issue) and writeback in the custom processor datapath.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 0, 1 = entry 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write enable (writeback).
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- ra1, ra2, ra3  in  ADDR_W  read addresses (src1, src2, dst).
- rd1, rd2, rd3  out  DATA_W  read data.
- bs_set  in  1  mark register bs_addr busy (instruction issued with that dest).
- bs_addr  in  ADDR_W  busy-set address.
- busy1, busy2, busy3  out  1  scoreboard bit of ra1/ra2/ra3.
- clr_req  in  1  request soft clear of all registers and busy bits.
- ready  out  1  1 = idle; writes, bs_set and clr_req accepted.

Behaviour:
- Async reset (rst=1): all entries=0, all busy bits=0, FSM=IDLE, ready=1, clear counter=0. Reset mid-sweep aborts the sweep immediately.
- Reads: combinational, zero latency. rdN = mem[raN]. busyN = busy[raN].
- Write: when we && ready, mem[waddr] <= wdata and busy[waddr] <= 0 at the next edge.
- Busy set: when bs_set && ready, busy[bs_addr] <= 1.
- Simultaneous we and bs_set, same address: set wins (new producer issued), busy ends at 1, data still written.
- Different addresses: both take effect.
- ZERO_REG=1: writes to address 0 are dropped; bs_set to 0 is ignored; rdN=0 and busyN=0 whenever raN=0.
- FSM states IDLE and CLEAR.
  - IDLE, ready=1: clr_req=1 moves to CLEAR with cnt=0. Any we/bs_set in that same cycle is still applied.
  - CLEAR, ready=0: each cycle mem[cnt] <= 0, busy[cnt] <= 0, cnt <= cnt+1. we, bs_set and clr_req are ignored.
  - When cnt == DEPTH-1, that entry is cleared and the FSM returns to IDLE. Sweep length is exactly DEPTH cycles, with ready rising the cycle after the last entry is cleared.
  - cnt is ADDR_W bits and wraps naturally; no extra bit is needed.
- Reads during CLEAR return the current contents: cleared entries read 0, uncleared entries read their old value.
- No X on outputs after reset. Out-of-range addresses are impossible because DEPTH is a power of two.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined: write-through bypass. If we && ready && waddr==raN (and not the zero register), rdN=wdata and busyN=0 combinationally in the same cycle, unless bs_set targets the same address, in which case busyN=1.
- Undefined: reads see the new value and busy update only after the clock edge.

Decomposition:
- Package regfile_sb_pkg: FSM state enum (ST_IDLE, ST_CLEAR), default DATA_W/ADDR_W constants, and the shared read-port count constant (3).
- One natural sub-module, regfile_sb_clr_fsm: owns state, cnt and ready; outputs clr_active and clr_addr.
- Storage, scoreboard and read muxes stay in the top level.

Test Plan:
- Reset then write: pulse rst, we=1 waddr=5 wdata=16'hBEEF, then ra1=5 -> rd1=16'h0000 before the edge, 16'hBEEF after; busy1=0 throughout.
- Scoreboard: bs_set at addr 3 -> busy2=1 with ra2=3 next cycle. we addr 3 data 16'h1234 -> busy2=0, rd2=16'h1234. Same-cycle bs_set+we on addr 3 -> busy2=1, rd2 holds the new data.
- Zero register (ZERO_REG=1): we addr 0 data 16'hFFFF and bs_set addr 0 -> rd1=0, busy1=0 with ra1=0.
- Soft clear (DEPTH=8, all regs preloaded nonzero, all busy): clr_req -> ready=0 for exactly 8 cycles. A we during the sweep is dropped. Afterwards all rdN=0, all busyN=0, ready=1.
- Reset mid-clear: assert rst at sweep cycle 3 -> immediate ready=1 and all entries 0. A subsequent write works on the next edge.
- Bypass (macro defined): we addr 2 data 16'hA5A5 with ra3=2 -> rd3=16'hA5A5 in the same cycle. Macro undefined -> old value that cycle, 16'hA5A5 the next.
